// File: rtl/text_buffer.sv
// text_buffer: char/attr tile store with cursor puts, circular-offset scroll and self-timed clear
module text_buffer #(
  parameter int H_TILES = 80,
  parameter int V_TILES = 30,
  parameter int CHAR_WIDTH = 7,
  parameter int ATTR_WIDTH = 4,
  parameter int DATA_WIDTH = CHAR_WIDTH + ATTR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BLANK = '0,
  parameter logic [CHAR_WIDTH-1:0] NEWLINE_CODE = CHAR_WIDTH'('h0A),
  parameter int COL_W = $clog2(H_TILES),
  parameter int ROW_W = $clog2(V_TILES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [COL_W-1:0]      col_w_i,
  input  logic [ROW_W-1:0]      row_w_i,
  input  logic                  put_en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  clr_i,
  input  logic                  scroll_i,
  input  logic [COL_W-1:0]      col_r_i,
  input  logic [ROW_W-1:0]      row_r_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  busy_o,
  output logic [COL_W-1:0]      cur_col_o,
  output logic [ROW_W-1:0]      cur_row_o
);
  localparam int NUM_TILES = H_TILES * V_TILES;
  localparam int AW = $clog2(NUM_TILES);
  localparam logic [COL_W-1:0] H_MAX = COL_W'(H_TILES - 1);
  localparam logic [ROW_W-1:0] V_MAX = ROW_W'(V_TILES - 1);
  localparam logic [ROW_W:0] V_N = (ROW_W+1)'(V_TILES);
  localparam logic [AW-1:0] LAST = AW'(NUM_TILES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

  state_t state;
  logic [AW-1:0] cnt;
  logic [ROW_W-1:0] offset, srow, row;
  logic [COL_W-1:0] col;
  logic [DATA_WIDTH-1:0] mem [NUM_TILES];
  logic we, put_wr, dir_wr, idle_cmd, is_nl, adv_row, rd_ok;
  logic [AW-1:0] waddr, raddr;
  logic [ROW_W-1:0] off_nx;

  function automatic logic [ROW_W-1:0] phys(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] off);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, off};
    return s >= V_N ? ROW_W'(s - V_N) : ROW_W'(s);
  endfunction

  function automatic logic [AW-1:0] taddr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return AW'(r) * AW'(H_TILES) + AW'(c);
  endfunction

  // write-port arbitration: bulk FSM writes first, then put, then direct write
  always_comb begin
    is_nl = din_i[CHAR_WIDTH-1:0] == NEWLINE_CODE;
    adv_row = is_nl || col == H_MAX;
    off_nx = offset == V_MAX ? '0 : offset + 1'b1;
    idle_cmd = state == IDLE && !clr_i && !scroll_i;
    put_wr = idle_cmd && put_en_i && !is_nl;
    dir_wr = idle_cmd && !put_en_i && wr_en_i && col_w_i <= H_MAX && row_w_i <= V_MAX;
    we = !rst_i && (state != IDLE || put_wr || dir_wr);
    waddr = state == CLEAR  ? cnt :
            state == SCROLL ? taddr(srow, cnt[COL_W-1:0]) :
            put_en_i        ? taddr(phys(row, offset), col) :
                              taddr(phys(row_w_i, offset), col_w_i);
    rd_ok = col_r_i <= H_MAX && row_r_i <= V_MAX;
    raddr = taddr(phys(row_r_i, offset), col_r_i);
  end

  // tile memory write port
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= state == IDLE ? din_i : BLANK;
  end

  // registered read-first port, out-of-range reads return BLANK
  always_ff @(posedge clk_i) begin
    if (rst_i) dout_o <= '0;
    else dout_o <= rd_ok ? mem[raddr] : BLANK;
  end

  // command FSM: cursor, scroll offset and bulk clear sequencing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CLEAR;
      cnt <= '0;
      busy_o <= 1'b1;
      offset <= '0;
      srow <= '0;
      col <= '0;
      row <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (clr_i) begin
            state <= CLEAR;
            busy_o <= 1'b1;
            offset <= '0;
            col <= '0;
            row <= '0;
          end else if (scroll_i) begin
            state <= SCROLL;
            busy_o <= 1'b1;
            srow <= offset;
            offset <= off_nx;
            row <= row == '0 ? '0 : row - 1'b1;
          end else if (put_en_i) begin
            col <= adv_row ? '0 : col + 1'b1;
            if (adv_row && row == V_MAX) begin
              state <= SCROLL;
              busy_o <= 1'b1;
              srow <= offset;
              offset <= off_nx;
            end else if (adv_row) begin
              row <= row + 1'b1;
            end
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            busy_o <= 1'b0;
          end
        end
        SCROLL: begin
          cnt <= cnt + 1'b1;
          if (cnt[COL_W-1:0] == H_MAX) begin
            state <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_col_o = col;
  assign cur_row_o = row;
endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: directed checks of clear, direct/put writes, wrap, newline, scroll and reset
module tb_text_buffer;
  logic clk_i = 1'b0, rst_i = 1'b0, wr_en_i = 1'b0, put_en_i = 1'b0, clr_i = 1'b0, scroll_i = 1'b0;
  logic [6:0] col_w_i = '0, col_r_i = '0, cur_col_o;
  logic [4:0] row_w_i = '0, row_r_i = '0, cur_row_o;
  logic [10:0] din_i = '0, dout_o;
  logic busy_o;
  int n_cmp = 0, n_bad = 0;

  text_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .col_w_i(col_w_i), .row_w_i(row_w_i),
    .put_en_i(put_en_i), .din_i(din_i), .clr_i(clr_i), .scroll_i(scroll_i),
    .col_r_i(col_r_i), .row_r_i(row_r_i), .dout_o(dout_o), .busy_o(busy_o),
    .cur_col_o(cur_col_o), .cur_row_o(cur_row_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input int c, input int r, input int exp, input string tag);
    col_r_i = 7'(c);
    row_r_i = 5'(r);
    tick;
    chk(tag, int'(dout_o), exp);
  endtask

  task automatic cur(input int c, input int r, input string tag);
    chk({tag, ".col"}, int'(cur_col_o), c);
    chk({tag, ".row"}, int'(cur_row_o), r);
  endtask

  task automatic wait_idle(input int exp, input string tag);
    int n = 0;
    while (busy_o && n < 5000) begin
      tick;
      n++;
    end
    chk(tag, n, exp);
  endtask

  task automatic wr(input int c, input int r, input int d);
    col_w_i = 7'(c);
    row_w_i = 5'(r);
    din_i = 11'(d);
    wr_en_i = 1'b1;
    tick;
    wr_en_i = 1'b0;
  endtask

  task automatic put(input int d);
    din_i = 11'(d);
    put_en_i = 1'b1;
    tick;
    put_en_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("rst_busy", int'(busy_o), 1);
    chk("rst_dout", int'(dout_o), 0);
    cur(0, 0, "rst_cur");
    wait_idle(2400, "rst_clear_len");
    rd(79, 29, 0, "blank_79_29");

    wr(5, 3, 'h4C1);
    rd(5, 3, 'h4C1, "wr_5_3");
    cur(0, 0, "wr_cur");
    wr(80, 4, 'h123);
    rd(0, 4, 0, "wr_col80_drop");
    wr(0, 1, 'h555);
    rd(80, 0, 0, "rd_oob_blank");
    rd(0, 1, 'h555, "wr_0_1");

    col_w_i = 7'd10; row_w_i = 5'd10; wr_en_i = 1'b1;
    for (int i = 0; i < 80; i++) put('h141);
    wr_en_i = 1'b0;
    cur(0, 1, "wrap_cur");
    rd(10, 10, 0, "put_beats_wr");
    rd(0, 0, 'h141, "put_0_0");
    rd(79, 0, 'h141, "put_79_0");

    wr(7, 1, 'h3B2);
    for (int i = 0; i < 7; i++) put('h142);
    cur(7, 1, "seven_cur");
    put('h28A);
    cur(0, 2, "nl_cur");
    rd(7, 1, 'h3B2, "nl_nowrite");
    rd(6, 1, 'h142, "put_6_1");

    for (int i = 0; i < 27; i++) put('h00A);
    cur(0, 29, "nl27_cur");
    for (int i = 0; i < 79; i++) put('h159);
    cur(79, 29, "fill29_cur");
    put('h15A);
    chk("auto_busy", int'(busy_o), 1);
    cur(0, 29, "auto_cur");
    wr(5, 2, 'h7FF);
    put('h141);
    wait_idle(78, "auto_scroll_len");
    cur(0, 29, "auto_cur_after");
    rd(0, 28, 'h159, "auto_0_28");
    rd(78, 28, 'h159, "auto_78_28");
    rd(79, 28, 'h15A, "auto_79_28");
    rd(0, 29, 0, "auto_0_29");
    rd(79, 29, 0, "auto_79_29");
    rd(5, 2, 'h4C1, "busy_wr_drop");
    rd(7, 0, 'h3B2, "auto_7_0");
    rd(6, 0, 'h142, "auto_6_0");

    scroll_i = 1'b1;
    tick;
    scroll_i = 1'b0;
    chk("scroll_busy", int'(busy_o), 1);
    cur(0, 28, "scroll_cur");
    wait_idle(80, "scroll_len");
    rd(79, 27, 'h15A, "scroll_79_27");
    rd(79, 28, 0, "scroll_79_28");
    rd(5, 1, 'h4C1, "scroll_5_1");

    clr_i = 1'b1; scroll_i = 1'b1; put_en_i = 1'b1; din_i = 11'h141;
    tick;
    clr_i = 1'b0; scroll_i = 1'b0; put_en_i = 1'b0;
    chk("prio_busy", int'(busy_o), 1);
    cur(0, 0, "prio_cur");
    wait_idle(2400, "prio_clear_len");
    rd(5, 1, 0, "clr_5_1");
    rd(79, 27, 0, "clr_79_27");
    rd(0, 0, 0, "clr_0_0");

    scroll_i = 1'b1;
    tick;
    scroll_i = 1'b0;
    cur(0, 0, "scroll_row0_cur");
    wait_idle(80, "scroll_row0_len");

    wr(3, 3, 'h4C1);
    put('h141);
    cur(1, 0, "pre_rst_cur");
    scroll_i = 1'b1;
    tick;
    scroll_i = 1'b0;
    for (int i = 0; i < 40; i++) tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("midrst_busy", int'(busy_o), 1);
    cur(0, 0, "midrst_cur");
    wait_idle(2400, "midrst_clear_len");
    rd(3, 3, 0, "midrst_3_3");
    rd(3, 2, 0, "midrst_3_2");
    rd(0, 0, 0, "midrst_0_0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/text_buffer.md
# text_buffer

Parametrised character/attribute tile buffer for the VGA text path. It sits between the host-side text writer and the pixel pipeline's glyph lookup. It stores one char code plus colour attribute per tile and offers both direct-addressed writes and a cursor-driven "put char" port with newline handling. Hardware scroll uses a circular row offset, and bulk operations (full clear, row clear on scroll) run as a self-timed FSM.

## Interface
Parameters:
- H_TILES, 80, tiles per row (640/8)
- V_TILES, 30, tile rows (480/16)
- CHAR_WIDTH, 7, char code width
- ATTR_WIDTH, 4, attribute (fg colour index) width; DATA_WIDTH = CHAR_WIDTH+ATTR_WIDTH (derived)
- BLANK, 0, DATA_WIDTH fill value used by clear/scroll
- NEWLINE_CODE, 7'h0A, char code that put_en_i interprets as newline
- COL_W/ROW_W, derived, $clog2(H_TILES)/$clog2(V_TILES)

Ports:
- clk_i  in  1  25 MHz pixel clock
- rst_i  in  1  synchronous, active-high reset
- wr_en_i  in  1  direct write strobe
- col_w_i / row_w_i  in  COL_W / ROW_W  logical tile for direct write
- put_en_i  in  1  cursor write strobe
- din_i  in  DATA_WIDTH  {attr, char} for wr_en_i or put_en_i
- clr_i  in  1  start full clear
- scroll_i  in  1  scroll up one row
- col_r_i / row_r_i  in  COL_W / ROW_W  logical tile to read
- dout_o  out  DATA_WIDTH  read data, registered
- busy_o  out  1  FSM in CLEAR or SCROLL
- cur_col_o / cur_row_o  out  COL_W / ROW_W  cursor position

## Operation
- Memory: NUM_TILES = H_TILES*V_TILES words. Initialised to BLANK at configuration.
- Row mapping: physical row = (logical row + offset) mod V_TILES. Offset is ROW_W bits and wraps V_TILES-1 -> 0. Addr = phys_row*H_TILES + col. Both read and write use this mapping.
- FSM states:
  - IDLE: accepts commands.
  - CLEAR: counter 0..NUM_TILES-1 writes BLANK, then returns to IDLE. offset=0, cursor=(0,0) on entry.
  - SCROLL: counter 0..H_TILES-1 writes BLANK along one physical row, then returns to IDLE.
- Command priority in IDLE, one accepted per cycle: clr_i > scroll_i > put_en_i > wr_en_i. Lower-priority strobes in the same cycle are dropped.
- While busy_o=1, all write/command strobes are dropped with no queuing. Reads continue.
- Direct write: writes din_i at mapped (col_w_i,row_w_i). If col_w_i>=H_TILES or row_w_i>=V_TILES, the write is dropped. Cursor is unchanged.
- put char, char field != NEWLINE_CODE:
  - Write din_i at cursor.
  - If col < H_TILES-1: col+1. Otherwise col=0 and advance row.
- put char, char field == NEWLINE_CODE: no write; col=0; advance row.
- Advance row: if row < V_TILES-1, row+1. Otherwise row stays V_TILES-1 and an auto-scroll is started in the same cycle.
- Scroll (scroll_i or auto):
  - offset <= (offset+1) mod V_TILES.
  - Enter SCROLL, clearing physical row = old offset (the new logical bottom row).
  - scroll_i additionally sets cursor row = max(row-1, 0), col unchanged.
  - Auto-scroll leaves the cursor at (0, V_TILES-1).
- Read: dout_o <= mem[mapped addr]. An out-of-range read coordinate returns BLANK.

## Timing
- Reset (rst_i=1 at edge): dout_o=0, offset=0, cursor=(0,0), FSM enters CLEAR with counter=0, busy_o=1.
  - After rst_i deasserts, busy_o stays 1 for NUM_TILES cycles (2400 default), then drops to 0.
  - Reset asserted mid-CLEAR or mid-SCROLL restarts CLEAR from counter 0.
- busy_o is registered. It goes 1 on the edge that accepts clr_i/scroll_i (or auto-scroll) and returns 0 on the edge after the last BLANK write. CLEAR holds busy for NUM_TILES cycles, SCROLL for H_TILES.
- Read latency: 1 cycle, reflecting the offset value registered before the sampling edge.
- Read during write to the same address in the same cycle returns the old data (read-first).
- Cursor outputs and offset update on the accepting edge.
- put_en_i may assert every cycle in IDLE, sustaining 1 char/cycle until an auto-scroll raises busy_o.

## Test plan
- Reset then idle: assert rst_i 1 cycle -> busy_o=1 for 2400 cycles, then 0. Reading (79,29) gives 0, and cur=(0,0).
- Direct write/read: write 0x4C1 at (5,3), read (5,3) -> dout_o=0x4C1 one cycle later. A write to col 80 is dropped and reading (0,4) stays 0.
- Cursor wrap and newline:
  - 80 puts of 'A' from (0,0) -> cur=(0,1).
  - put 0x0A at (7,1) -> cur=(0,2), and (7,1) is unchanged.
- Auto-scroll:
  - Fill row 0 with 'X'. Set cursor to (79,29) via puts, then put 'Z' -> offset=1, busy_o=1 for 80 cycles, cur=(0,29).
  - Afterwards, logical row 28 reads the old row 29 contents and logical row 29 reads all BLANK.
- Priority/busy drop:
  - clr_i, scroll_i, put_en_i asserted in the same cycle -> only clear runs, cursor=(0,0), offset=0.
  - wr_en_i during busy -> no memory change.
- Reset mid-scroll: rst_i 40 cycles into SCROLL -> CLEAR restarts, offset=0, busy_o=1 for 2400 cycles, all tiles BLANK.
